// File: rtl/tabuleiro_pkg.sv
// Shared sizes, FSM encoding and helpers for the Batalha Naval board store.
package tabuleiro_pkg;
  localparam int DIM   = 8;
  localparam int CNT_W = 7;
  localparam int CW    = $clog2(DIM);
  localparam int AW    = CW + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_VAL_RD, S_VAL_WR, S_COL_RD, S_COL_WR
  } state_t;

  function automatic logic [AW-1:0] idx(input logic jogador, input logic [CW-1:0] row);
    return {jogador, row};
  endfunction

  function automatic logic [CNT_W-1:0] popcount(input logic [DIM-1:0] v);
    popcount = '0;
    for (int i = 0; i < DIM; i++) popcount += CNT_W'(v[i]);
  endfunction
endpackage

// File: rtl/tabuleiro_ram.sv
// One board plane: single write port, registered read (1-cycle latency).
module tabuleiro_ram #(
  parameter int W  = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/tabuleiro_mem.sv
// Board store for both players: placement RMW, shot RMW, remaining-cell counters, game over.
module tabuleiro_mem
  import tabuleiro_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             limpar,
  output logic             busy,
  input  logic             val_req,
  input  logic             val_we,
  input  logic             val_jogador,
  input  logic [CW-1:0]    val_addr,
  input  logic [DIM-1:0]   val_wdata,
  output logic             val_ack,
  output logic [DIM-1:0]   val_rdata,
  input  logic             col_req,
  input  logic             col_jogador,
  input  logic [CW-1:0]    col_x,
  input  logic [CW-1:0]    col_y,
  output logic             col_ack,
  output logic             col_hit,
  output logic             col_repete,
  output logic [CNT_W-1:0] restante_p1,
  output logic [CNT_W-1:0] restante_p2,
  output logic             fim_jogo,
  output logic             vencedor
);
  state_t state, state_nx;
  logic [AW-1:0]    clr_cnt;
  logic             lim_pend;
  logic             op_jog, op_we;
  logic [CW-1:0]    op_row, op_x;
  logic [DIM-1:0]   op_wdata;
  logic [DIM-1:0]   navio_q, tiro_q, navio_wd, tiro_wd;
  logic             navio_we, tiro_we, clearing;
  logic [AW-1:0]    waddr;
  logic [CNT_W-1:0] added, tgt_cnt;
  logic             hit, rep, tgt_armed, armed_p1, armed_p2;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_CLEAR;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_CLEAR:  if (clr_cnt == '1) state_nx = S_IDLE;
      S_IDLE: begin
        if (lim_pend || limpar) state_nx = S_CLEAR;
        else if (col_req)       state_nx = S_COL_RD;
        else if (val_req)       state_nx = S_VAL_RD;
      end
      S_VAL_RD: state_nx = S_VAL_WR;
      S_VAL_WR: state_nx = S_IDLE;
      S_COL_RD: state_nx = S_COL_WR;
      S_COL_WR: state_nx = S_IDLE;
      default:  state_nx = S_CLEAR;
    endcase
  end

  assign busy      = (state != S_IDLE);
  assign clearing  = (state == S_CLEAR);
  assign waddr     = clearing ? clr_cnt : idx(op_jog, op_row);
  assign navio_we  = clearing || (state == S_VAL_WR && op_we);
  assign tiro_we   = clearing || (state == S_COL_WR);
  assign navio_wd  = clearing ? '0 : (navio_q | op_wdata);
  assign tiro_wd   = clearing ? '0 : (tiro_q | (DIM'(1) << op_x));
  // Only bits not already holding a ship add to the owner's count.
  assign added     = popcount(op_wdata & ~navio_q);
  assign hit       = navio_q[op_x];
  assign rep       = tiro_q[op_x];
  assign tgt_cnt   = op_jog ? restante_p2 : restante_p1;
  assign tgt_armed = op_jog ? armed_p2 : armed_p1;

  tabuleiro_ram #(.W(DIM), .AW(AW)) u_navio (
    .clk(clk), .we(navio_we), .waddr(waddr), .wdata(navio_wd),
    .raddr(idx(op_jog, op_row)), .rdata(navio_q)
  );

  tabuleiro_ram #(.W(DIM), .AW(AW)) u_tiro (
    .clk(clk), .we(tiro_we), .waddr(waddr), .wdata(tiro_wd),
    .raddr(idx(op_jog, op_row)), .rdata(tiro_q)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clr_cnt <= '0; lim_pend <= 1'b0;
      op_jog <= 1'b0; op_we <= 1'b0; op_row <= '0; op_x <= '0; op_wdata <= '0;
      val_ack <= 1'b0; val_rdata <= '0;
      col_ack <= 1'b0; col_hit <= 1'b0; col_repete <= 1'b0;
      restante_p1 <= '0; restante_p2 <= '0;
      armed_p1 <= 1'b0; armed_p2 <= 1'b0;
      fim_jogo <= 1'b0; vencedor <= 1'b0;
    end else begin
      val_ack <= 1'b0;
      col_ack <= 1'b0;
      if (state == S_IDLE && state_nx == S_CLEAR) lim_pend <= 1'b0;
      else if (limpar)                            lim_pend <= 1'b1;
      clr_cnt <= clearing ? clr_cnt + 1'b1 : '0;
      case (state)
        S_IDLE: begin
          if (state_nx == S_COL_RD) begin
            op_jog <= col_jogador; op_row <= col_y; op_x <= col_x;
          end else if (state_nx == S_VAL_RD) begin
            op_jog <= val_jogador; op_row <= val_addr;
            op_we <= val_we; op_wdata <= val_wdata;
          end
        end
        S_CLEAR: begin
          restante_p1 <= '0; restante_p2 <= '0;
          armed_p1 <= 1'b0; armed_p2 <= 1'b0;
          fim_jogo <= 1'b0; vencedor <= 1'b0;
        end
        S_VAL_WR: begin
          val_ack   <= 1'b1;
          val_rdata <= navio_q;
          if (op_we) begin
            if (op_jog) begin
              restante_p2 <= restante_p2 + added;
              if (|navio_wd) armed_p2 <= 1'b1;
            end else begin
              restante_p1 <= restante_p1 + added;
              if (|navio_wd) armed_p1 <= 1'b1;
            end
          end
        end
        S_COL_WR: begin
          col_ack    <= 1'b1;
          col_hit    <= hit;
          col_repete <= rep;
          // Counter saturates at zero; game ends only on a real 1 -> 0 step.
          if (hit && !rep && tgt_cnt != '0) begin
            if (op_jog) restante_p2 <= restante_p2 - 1'b1;
            else        restante_p1 <= restante_p1 - 1'b1;
            if (tgt_cnt == CNT_W'(1) && tgt_armed) begin
              fim_jogo <= 1'b1;
              vencedor <= ~op_jog;
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_tabuleiro_mem.sv
// Self-checking bench: directed table, corner sequences, random ops against a board model.
module tb_tabuleiro_mem;
  import tabuleiro_pkg::*;

  logic clk, reset, limpar, busy;
  logic val_req, val_we, val_jogador, val_ack;
  logic [2:0] val_addr;
  logic [7:0] val_wdata, val_rdata;
  logic col_req, col_jogador, col_ack, col_hit, col_repete;
  logic [2:0] col_x, col_y;
  logic [6:0] restante_p1, restante_p2;
  logic fim_jogo, vencedor;

  int checks = 0;
  int errors = 0;

  tabuleiro_mem dut (
    .clk(clk), .reset(reset), .limpar(limpar), .busy(busy),
    .val_req(val_req), .val_we(val_we), .val_jogador(val_jogador),
    .val_addr(val_addr), .val_wdata(val_wdata), .val_ack(val_ack), .val_rdata(val_rdata),
    .col_req(col_req), .col_jogador(col_jogador), .col_x(col_x), .col_y(col_y),
    .col_ack(col_ack), .col_hit(col_hit), .col_repete(col_repete),
    .restante_p1(restante_p1), .restante_p2(restante_p2),
    .fim_jogo(fim_jogo), .vencedor(vencedor)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  // Board model: plain arrays and integer counters following the game rules.
  logic [7:0] m_navio [16];
  logic [7:0] m_tiro  [16];
  int m_r [2];
  bit m_armed [2];
  bit m_fim, m_venc;

  typedef struct {
    bit is_col; bit jog; bit we; int row; int x; logic [7:0] wd;
    logic [7:0] e_rd; bit e_hit; bit e_rep; int e_r1; int e_r2; bit e_fim; bit e_venc;
  } vec_t;
  vec_t tbl [11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic m_clear();
    for (int i = 0; i < 16; i++) begin m_navio[i] = 0; m_tiro[i] = 0; end
    m_r[0] = 0; m_r[1] = 0; m_armed[0] = 0; m_armed[1] = 0; m_fim = 0; m_venc = 0;
  endtask

  task automatic m_op(input bit is_col, input bit jog, input bit we, input int row, input int x,
                      input logic [7:0] wd, output logic [7:0] e_rd, output bit e_hit, output bit e_rep);
    int i;
    i = jog * 8 + row;
    e_rd = m_navio[i];
    e_hit = m_navio[i][x];
    e_rep = m_tiro[i][x];
    if (is_col) begin
      m_tiro[i][x] = 1'b1;
      if (e_hit && !e_rep && m_r[jog] > 0) begin
        m_r[jog]--;
        if (m_r[jog] == 0 && m_armed[jog]) begin m_fim = 1; m_venc = !jog; end
      end
    end else if (we) begin
      m_r[jog] += $countones(wd & ~m_navio[i]);
      m_navio[i] = m_navio[i] | wd;
      if (m_navio[i] != 0) m_armed[jog] = 1;
    end
  endtask

  task automatic chk_model(input string nm);
    chk({nm, ".r1"}, 32'(restante_p1), m_r[0]);
    chk({nm, ".r2"}, 32'(restante_p2), m_r[1]);
    chk({nm, ".fim"}, 32'(fim_jogo), 32'(m_fim));
    if (m_fim) chk({nm, ".venc"}, 32'(vencedor), 32'(m_venc));
  endtask

  // Issue one request, wait (bounded) for its ack, then check the ack drops.
  task automatic run_op(input bit is_col, input bit jog, input bit we, input int row, input int x,
                        input logic [7:0] wd, output logic [7:0] rd, output bit hit, output bit rep,
                        output int lat);
    logic ack;
    if (is_col) begin
      col_jogador = jog; col_x = x[2:0]; col_y = row[2:0]; col_req = 1;
    end else begin
      val_jogador = jog; val_we = we; val_addr = row[2:0]; val_wdata = wd; val_req = 1;
    end
    lat = 0;
    do begin
      @(posedge clk); #1; lat++;
      ack = is_col ? col_ack : val_ack;
    end while (!ack && lat < 40);
    chk("ack_seen", 32'(ack), 1);
    rd = val_rdata; hit = col_hit; rep = col_repete;
    col_req = 0; val_req = 0;
    @(posedge clk); #1;
    chk("ack_pulse", 32'(is_col ? col_ack : val_ack), 0);
  endtask

  task automatic wait_clear(input string nm);
    int cnt;
    cnt = 0;
    while (busy && cnt < 100) begin cnt++; @(posedge clk); #1; end
    chk(nm, cnt, 16);
  endtask

  initial begin
    logic [7:0] rd, e_rd;
    bit hit, rep, e_hit, e_rep, c_seen, v_seen;
    int lat, w, c_lat, v_lat;
    bit is_col, jog, we;
    int row, x;
    logic [7:0] wd;

    tbl[0]  = '{0, 0, 1, 2, 0, 8'h1C, 8'h00, 0, 0, 3, 0, 0, 0};
    tbl[1]  = '{0, 0, 1, 2, 0, 8'h18, 8'h1C, 0, 0, 3, 0, 0, 0};
    tbl[2]  = '{0, 0, 0, 2, 0, 8'h00, 8'h1C, 0, 0, 3, 0, 0, 0};
    tbl[3]  = '{1, 0, 0, 2, 3, 8'h00, 8'h00, 1, 0, 2, 0, 0, 0};
    tbl[4]  = '{1, 0, 0, 2, 3, 8'h00, 8'h00, 1, 1, 2, 0, 0, 0};
    tbl[5]  = '{1, 0, 0, 2, 0, 8'h00, 8'h00, 0, 0, 2, 0, 0, 0};
    tbl[6]  = '{1, 0, 0, 2, 2, 8'h00, 8'h00, 1, 0, 1, 0, 0, 0};
    tbl[7]  = '{1, 0, 0, 2, 4, 8'h00, 8'h00, 1, 0, 0, 0, 1, 1};
    tbl[8]  = '{1, 0, 0, 2, 4, 8'h00, 8'h00, 1, 1, 0, 0, 1, 1};
    tbl[9]  = '{0, 1, 1, 7, 0, 8'h81, 8'h00, 0, 0, 0, 2, 1, 1};
    tbl[10] = '{1, 1, 0, 7, 7, 8'h00, 8'h00, 1, 0, 0, 1, 1, 1};

    reset = 0; limpar = 0;
    val_req = 0; val_we = 0; val_jogador = 0; val_addr = 0; val_wdata = 0;
    col_req = 0; col_jogador = 0; col_x = 0; col_y = 0;
    m_clear();
    repeat (3) @(posedge clk);
    #1;
    chk("rst.busy", 32'(busy), 1);
    chk("rst.val_ack", 32'(val_ack), 0);
    chk("rst.col_ack", 32'(col_ack), 0);
    chk("rst.val_rdata", 32'(val_rdata), 0);
    chk("rst.hit_rep", 32'({col_hit, col_repete}), 0);
    chk("rst.r1", 32'(restante_p1), 0);
    chk("rst.r2", 32'(restante_p2), 0);
    chk("rst.fim_venc", 32'({fim_jogo, vencedor}), 0);
    reset = 1;
    wait_clear("rst.busy_len");

    for (int i = 0; i < 11; i++) begin
      run_op(tbl[i].is_col, tbl[i].jog, tbl[i].we, tbl[i].row, tbl[i].x, tbl[i].wd, rd, hit, rep, lat);
      m_op(tbl[i].is_col, tbl[i].jog, tbl[i].we, tbl[i].row, tbl[i].x, tbl[i].wd, e_rd, e_hit, e_rep);
      chk($sformatf("tbl%0d.lat", i), lat, 3);
      if (tbl[i].is_col) begin
        chk($sformatf("tbl%0d.hit", i), 32'(hit), 32'(tbl[i].e_hit));
        chk($sformatf("tbl%0d.rep", i), 32'(rep), 32'(tbl[i].e_rep));
      end else
        chk($sformatf("tbl%0d.rdata", i), 32'(rd), 32'(tbl[i].e_rd));
      chk($sformatf("tbl%0d.r1", i), 32'(restante_p1), tbl[i].e_r1);
      chk($sformatf("tbl%0d.r2", i), 32'(restante_p2), tbl[i].e_r2);
      chk($sformatf("tbl%0d.fim", i), 32'(fim_jogo), 32'(tbl[i].e_fim));
      if (tbl[i].e_fim) chk($sformatf("tbl%0d.venc", i), 32'(vencedor), 32'(tbl[i].e_venc));
    end

    // Simultaneous requests: shot wins, placement waits for the next IDLE.
    col_jogador = 1; col_x = 3; col_y = 7; col_req = 1;
    val_jogador = 0; val_we = 1; val_addr = 5; val_wdata = 8'h0F; val_req = 1;
    c_seen = 0; v_seen = 0; c_lat = 0; v_lat = 0; w = 0;
    while (!(c_seen && v_seen) && w < 20) begin
      @(posedge clk); #1; w++;
      if (col_ack) begin c_seen = 1; c_lat = w; hit = col_hit; rep = col_repete; col_req = 0; end
      if (val_ack) begin v_seen = 1; v_lat = w; rd = val_rdata; val_req = 0; end
    end
    col_req = 0; val_req = 0;
    chk("simul.col_lat", c_lat, 3);
    chk("simul.val_lat", v_lat, 6);
    m_op(1, 1, 0, 7, 3, 8'h00, e_rd, e_hit, e_rep);
    chk("simul.hit_rep", 32'({hit, rep}), 32'({e_hit, e_rep}));
    m_op(0, 0, 1, 5, 0, 8'h0F, e_rd, e_hit, e_rep);
    chk("simul.rdata", 32'(rd), 32'(e_rd));
    @(posedge clk); #1;
    chk_model("simul");

    // limpar pulsed while a shot is in COL_RD: shot completes, then a full clear.
    col_jogador = 0; col_x = 1; col_y = 5; col_req = 1;
    @(posedge clk); #1;
    limpar = 1;
    @(posedge clk); #1;
    limpar = 0;
    @(posedge clk); #1;
    chk("limpar.col_ack", 32'(col_ack), 1);
    m_op(1, 0, 0, 5, 1, 8'h00, e_rd, e_hit, e_rep);
    chk("limpar.hit_rep", 32'({col_hit, col_repete}), 32'({e_hit, e_rep}));
    col_req = 0;
    w = 0;
    while (!busy && w < 5) begin @(posedge clk); #1; w++; end
    wait_clear("limpar.busy_len");
    m_clear();
    chk_model("limpar");
    for (int i = 0; i < 16; i++) begin
      run_op(0, i[3], 0, i % 8, 0, 8'h00, rd, hit, rep, lat);
      chk($sformatf("clr.row%0d", i), 32'(rd), 0);
    end

    // Random traffic on a fresh board against the model.
    for (int n = 0; n < 300; n++) begin
      is_col = 1'($urandom_range(0, 1));
      jog = 1'($urandom_range(0, 1));
      we = ($urandom_range(0, 3) != 0);
      row = $urandom_range(0, 7);
      x = $urandom_range(0, 7);
      wd = 8'($urandom & $urandom);
      run_op(is_col, jog, we, row, x, wd, rd, hit, rep, lat);
      m_op(is_col, jog, we, row, x, wd, e_rd, e_hit, e_rep);
      chk("rnd.lat", lat, 3);
      if (is_col) chk("rnd.hit_rep", 32'({hit, rep}), 32'({e_hit, e_rep}));
      else        chk("rnd.rdata", 32'(rd), 32'(e_rd));
      chk_model("rnd");
    end

    // Reset while a placement is in VAL_RD: no ack, write never lands.
    val_jogador = 0; val_we = 1; val_addr = 3; val_wdata = 8'hFF; val_req = 1;
    @(posedge clk); #1;
    reset = 0;
    #1;
    val_req = 0;
    chk("rstmid.val_ack", 32'(val_ack), 0);
    chk("rstmid.busy", 32'(busy), 1);
    chk("rstmid.cnt", 32'({restante_p1, restante_p2}), 0);
    chk("rstmid.fim_venc", 32'({fim_jogo, vencedor}), 0);
    repeat (2) @(posedge clk);
    #1;
    chk("rstmid.val_ack2", 32'(val_ack), 0);
    reset = 1;
    wait_clear("rstmid.busy_len");
    m_clear();
    run_op(0, 0, 0, 3, 0, 8'h00, rd, hit, rep, lat);
    chk("rstmid.row3", 32'(rd), 0);
    chk_model("rstmid");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
